// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
//   MM:SS elapsed-time counter kept as four BCD digits, advanced by a ~1 Hz
//   one-cycle tick and steered by a start/stop, lap and clear button FSM.
//
// Parameters
//   MIN_LIMIT  highest minute value shown (1..99); count ends at MIN_LIMIT:59
//   SATURATE   0: wrap to 00:00 at end of range, 1: hold and pause
//
// Ports
//   CLOCK_50    system clock, all flops on posedge
//   reset       synchronous active-high reset
//   tick        one-cycle count enable
//   start_stop  button level (synchronous), rising edge = press
//   lap         button level (synchronous), rising edge = press
//   clear       button level (synchronous), rising edge = press
//   sec_ones, sec_tens, min_ones, min_tens   displayed BCD digits
//   running     high in RUN or LAP
//   rollover    one-cycle pulse after the count reaches the end of range
module stopwatch_bcd #(
    parameter int MIN_LIMIT = 59,
    parameter bit SATURATE  = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    localparam logic [3:0] LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_O = 4'(MIN_LIMIT % 10);

    state_t    state;
    bcd_time_t cnt;
    bcd_time_t lap_q;
    bcd_time_t cnt_inc;
    bcd_time_t cnt_upd;
    logic [2:0] btn_q;   // {start_stop, lap, clear} from the previous cycle

    logic ss_p, lap_p, clr_p;
    logic count_en, at_end, sat_hit;

    assign ss_p  = start_stop & ~btn_q[2];
    assign lap_p = lap        & ~btn_q[1];
    assign clr_p = clear      & ~btn_q[0];

    assign count_en = tick && (state == S_RUN || state == S_LAP);
    assign at_end   = (cnt.mt == LIM_T) && (cnt.mo == LIM_O) &&
                      (cnt.st == 4'd5)  && (cnt.so == 4'd9);
    assign sat_hit  = count_en && at_end && SATURATE;

    // BCD increment with the digit carry chain; end of range wraps to zero.
    always_comb begin
        cnt_inc = cnt;
        if (at_end) begin
            cnt_inc = '0;
        end else if (cnt.so != 4'd9) begin
            cnt_inc.so = cnt.so + 4'd1;
        end else begin
            cnt_inc.so = 4'd0;
            if (cnt.st != 4'd5) begin
                cnt_inc.st = cnt.st + 4'd1;
            end else begin
                cnt_inc.st = 4'd0;
                if (cnt.mo != 4'd9) begin
                    cnt_inc.mo = cnt.mo + 4'd1;
                end else begin
                    cnt_inc.mo = 4'd0;
                    cnt_inc.mt = cnt.mt + 4'd1;
                end
            end
        end
    end

    // Live count after this edge; the lap latch captures this value so a
    // tick on the same cycle as the lap press is included.
    always_comb begin
        cnt_upd = cnt;
        if (count_en && !sat_hit)
            cnt_upd = cnt_inc;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lap_q    <= '0;
            rollover <= 1'b0;
            btn_q    <= 3'b111;   // a button held through reset is not a press
        end else begin
            btn_q    <= {start_stop, lap, clear};
            rollover <= count_en && at_end;
            cnt      <= cnt_upd;
            case (state)
                S_IDLE: begin
                    if (ss_p) state <= S_RUN;
                end
                S_RUN: begin
                    if (ss_p) begin
                        state <= S_PAUSE;
                    end else if (lap_p) begin
                        state <= S_LAP;
                        lap_q <= cnt_upd;
                    end
                end
                S_LAP: begin
                    if (ss_p)       state <= S_PAUSE;
                    else if (lap_p) state <= S_RUN;
                end
                S_PAUSE: begin
                    if (clr_p) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (ss_p) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Saturation at end of range wins over any button this cycle.
            if (sat_hit) state <= S_PAUSE;
        end
    end

    bcd_time_t disp;
    assign disp     = (state == S_LAP) ? lap_q : cnt;
    assign sec_ones = disp.so;
    assign sec_tens = disp.st;
    assign min_ones = disp.mo;
    assign min_tens = disp.mt;
    assign running  = (state == S_RUN) || (state == S_LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1, tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;

    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic       run0, roll0, run1, roll1;

    always #10 CLOCK_50 = ~CLOCK_50;

    // default build: wraps after 59:59
    stopwatch_bcd dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .rollover(roll0));

    // saturating build: holds at 01:59
    stopwatch_bcd #(.MIN_LIMIT(1), .SATURATE(1'b1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .rollover(roll1));

    wire [17:0] out0 = {mt0, mo0, st0, so0, run0, roll0};
    wire [17:0] out1 = {mt1, mo1, st1, so1, run1, roll1};

    // ---------------- behavioural model (seconds as an integer) ----------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    typedef struct {
        int s;
        int lp;
        int mode;
        bit pss, plap, pclr;
        bit roll;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, bit rst, bit tk, bit ss, bit lb,
                                  bit cl, int lim, bit sat);
        mdl_t n;
        bit ess, elap, ecl, hit;
        n = m;
        if (rst) begin
            n = '{0, 0, M_IDLE, 1'b1, 1'b1, 1'b1, 1'b0};
            return n;
        end
        ess  = ss && !m.pss;
        elap = lb && !m.plap;
        ecl  = cl && !m.pclr;
        n.pss = ss; n.plap = lb; n.pclr = cl;
        n.roll = 1'b0;
        hit = 1'b0;
        if (tk && (m.mode == M_RUN || m.mode == M_LAP)) begin
            if (m.s == (lim + 1) * 60 - 1) begin
                n.roll = 1'b1;
                if (sat) hit = 1'b1;
                else     n.s = 0;
            end else begin
                n.s = m.s + 1;
            end
        end
        case (m.mode)
            M_IDLE:  if (ess) n.mode = M_RUN;
            M_RUN:   if (ess) n.mode = M_PAUSE;
                     else if (elap) begin n.mode = M_LAP; n.lp = n.s; end
            M_LAP:   if (ess) n.mode = M_PAUSE;
                     else if (elap) n.mode = M_RUN;
            default: if (ecl) begin n.mode = M_IDLE; n.s = 0; end
                     else if (ess) n.mode = M_RUN;
        endcase
        if (hit) n.mode = M_PAUSE;
        return n;
    endfunction

    function automatic logic [17:0] exp_out(mdl_t m);
        int v, mm, ss;
        v  = (m.mode == M_LAP) ? m.lp : m.s;
        mm = v / 60;
        ss = v % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                (m.mode == M_RUN || m.mode == M_LAP), m.roll};
    endfunction

    mdl_t m0, m1;
    always @(posedge CLOCK_50) begin
        m0 <= step(m0, reset, tick, start_stop, lap, clear, 59, 1'b0);
        m1 <= step(m1, reset, tick, start_stop, lap, clear, 1, 1'b1);
    end

    int  tests = 0, fails = 0;
    bit  chk_en = 1'b0;

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            tests++;
            if (out0 !== exp_out(m0)) begin
                fails++;
                $display("FAIL model0 t=%0t got %h want %h", $time, out0, exp_out(m0));
            end
            tests++;
            if (out1 !== exp_out(m1)) begin
                fails++;
                $display("FAIL model1 t=%0t got %h want %h", $time, out1, exp_out(m1));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations --------
    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1; cyc();
        start_stop = 1'b0; cyc();
    endtask

    task automatic press_lap();
        lap = 1'b1; cyc();
        lap = 1'b0; cyc();
    endtask

    task automatic press_clr();
        clear = 1'b1; cyc();
        clear = 1'b0; cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0; cyc();
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        reset = 1'b0; cyc();
        chk_en = 1'b1;
        check("reset0", out0, {16'h0000, 1'b0, 1'b0});
        check("reset1", out1, {16'h0000, 1'b0, 1'b0});

        // ticks in IDLE are ignored, then count 3
        ticks(2);
        check("idle_ticks", out0, {16'h0000, 1'b0, 1'b0});
        press_ss();
        ticks(3);
        check("run_3", out0, {16'h0003, 1'b1, 1'b0});

        // carry chain, wrap and saturation
        do_reset();
        press_ss();
        ticks(59);
        check("t59", out0, {16'h0059, 1'b1, 1'b0});
        ticks(1);
        check("t60", out0, {16'h0100, 1'b1, 1'b0});
        ticks(59);
        check("sat_119", out1, {16'h0159, 1'b1, 1'b0});
        tick = 1'b1; cyc();
        check("sat_hit", out1, {16'h0159, 1'b0, 1'b1});
        tick = 1'b0; cyc();
        check("sat_roll_clr", out1, {16'h0159, 1'b0, 1'b0});
        ticks(480);
        check("t600", out0, {16'h1000, 1'b1, 1'b0});
        check("sat_hold", out1, {16'h0159, 1'b0, 1'b0});
        ticks(2999);
        check("t3599", out0, {16'h5959, 1'b1, 1'b0});
        tick = 1'b1; cyc();
        check("wrap", out0, {16'h0000, 1'b1, 1'b1});
        tick = 1'b0; cyc();
        check("wrap_roll_clr", out0, {16'h0000, 1'b1, 1'b0});

        // lap freeze
        do_reset();
        press_ss();
        ticks(5);
        press_lap();
        ticks(4);
        check("lap_frozen", out0, {16'h0005, 1'b1, 1'b0});
        press_clr();
        check("lap_clr_ign", out0, {16'h0005, 1'b1, 1'b0});
        press_lap();
        check("lap_release", out0, {16'h0009, 1'b1, 1'b0});
        press_clr();
        check("run_clr_ign", out0, {16'h0009, 1'b1, 1'b0});

        // pause with coincident tick, clear priority, held button over reset
        do_reset();
        press_ss();
        ticks(7);
        tick = 1'b1; start_stop = 1'b1; cyc();
        tick = 1'b0; start_stop = 1'b0; cyc();
        check("pause_tick", out0, {16'h0008, 1'b0, 1'b0});
        ticks(5);
        check("pause_hold", out0, {16'h0008, 1'b0, 1'b0});
        start_stop = 1'b1; clear = 1'b1; cyc();
        start_stop = 1'b0; clear = 1'b0; cyc();
        check("clr_prio", out0, {16'h0000, 1'b0, 1'b0});
        start_stop = 1'b1;
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0; cyc(); cyc();
        ticks(2);
        check("held_reset", out0, {16'h0000, 1'b0, 1'b0});
        start_stop = 1'b0; cyc();
        press_ss();
        ticks(1);
        check("after_release", out0, {16'h0001, 1'b1, 1'b0});

        chk_en = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
